dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer placed in front of the single-port data memory. It shares the memory between the CPU MEM stage (port 0) and a loader/debug master (port 1). It registers the winning command and drives the memory's mem_read/mem_write/address/write_data. It captures read_data and returns a one-cycle response pulse to the winning requester. Accepted requests are processed in order, at one per cycle, with a fixed latency.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between two requesters using round-robin
// arbitration. An accepted command is registered (stage C), drives the memory
// in the next cycle, and the result is registered into a one-cycle response
// pulse to the requester that issued it (stage R). Fixed latency of 2 cycles,
// one accept per cycle.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   reqN_valid/we/addr/wdata request from port N (0 = CPU MEM, 1 = loader)
//   reqN_ready              grant; accept happens on valid & ready
//   respN_valid/rdata/err   one-cycle response pulse to port N
//   mem_read/mem_write      memory strobes
//   mem_address             word index, zero-extended
//   mem_write_data          memory write data
//   mem_read_data           combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  logic             last_q, last_d;
  logic             grant0, grant1, accept;
  logic             acc_we;
  logic [31:0]      acc_addr, acc_wdata, acc_word;

  logic             c_vld_q, c_vld_d;
  logic             c_port_q, c_port_d;
  logic             c_we_q, c_we_d;
  logic             c_err_q, c_err_d;
  logic [IDX_W-1:0] c_idx_q, c_idx_d;
  logic [31:0]      c_wdata_q, c_wdata_d;

  logic             r_vld0_q, r_vld0_d;
  logic             r_vld1_q, r_vld1_d;
  logic [31:0]      r_rdata_q, r_rdata_d;
  logic             r_err_q, r_err_d;

  // ---- arbitration: last_q = 1 means port 1 was granted most recently,
  //      so port 0 wins a tie in that case (and right after reset)
  always_comb begin
    grant0    = req0_valid & (~req1_valid | last_q);
    grant1    = req1_valid & (~req0_valid | ~last_q);
    accept    = grant0 | grant1;
    last_d    = accept ? grant1 : last_q;
    acc_we    = grant1 ? req1_we    : req0_we;
    acc_addr  = grant1 ? req1_addr  : req0_addr;
    acc_wdata = grant1 ? req1_wdata : req0_wdata;
    acc_word  = {2'b00, acc_addr[31:2]};
    c_vld_d   = accept;
    c_port_d  = grant1;
    c_we_d    = acc_we;
    c_err_d   = acc_word >= 32'(DEPTH);
    c_idx_d   = acc_addr[IDX_W+1:2];
    c_wdata_d = acc_wdata;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---- stage C: registered command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      c_vld_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      c_vld_q <= c_vld_d;
    end
  end

  // Payload flops carry no reset; everything they feed is qualified by c_vld_q.
  always_ff @(posedge clk) begin
    c_port_q  <= c_port_d;
    c_we_q    <= c_we_d;
    c_err_q   <= c_err_d;
    c_idx_q   <= c_idx_d;
    c_wdata_q <= c_wdata_d;
  end

  always_comb begin
    mem_read       = c_vld_q & ~c_we_q & ~c_err_q;
    mem_write      = c_vld_q &  c_we_q & ~c_err_q;
    mem_address    = c_vld_q ? {{(32-IDX_W){1'b0}}, c_idx_q} : 32'd0;
    mem_write_data = c_vld_q ? c_wdata_q : 32'd0;
    r_vld0_d       = c_vld_q & ~c_port_q;
    r_vld1_d       = c_vld_q &  c_port_q;
    r_rdata_d      = mem_read ? mem_read_data : 32'd0;
    r_err_d        = c_vld_q & c_err_q;
  end

  // ---- stage R: response pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld0_q <= 1'b0;
      r_vld1_q <= 1'b0;
    end else begin
      r_vld0_q <= r_vld0_d;
      r_vld1_q <= r_vld1_d;
    end
  end

  always_ff @(posedge clk) begin
    r_rdata_q <= r_rdata_d;
    r_err_q   <= r_err_d;
  end

  // Response payload is forced to zero whenever the port's pulse is absent.
  always_comb begin
    resp0_valid = r_vld0_q;
    resp1_valid = r_vld1_q;
    resp0_rdata = r_vld0_q ? r_rdata_q : 32'd0;
    resp1_rdata = r_vld1_q ? r_rdata_q : 32'd0;
    resp0_err   = r_vld0_q & r_err_q;
    resp1_err   = r_vld1_q & r_err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req0_ready;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_we, req1_ready;
  logic [31:0] req1_addr, req1_wdata;
  logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(1024), .IDX_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Single-port memory behind the arbiter
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_address[9:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 32'd0, 32'd0);
    drv1(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    // ---- reset state; ready follows valid but nothing is accepted
    drv1(1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ready1", 32'(req1_ready), 32'd1);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_addr", mem_address, 32'd0);
    check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    check("rst_resp1_rdata", resp1_rdata, 32'd0);
    next_cycle();
    idle();
    rst_n = 1'b1;

    // ---- write 0x10 = DEADBEEF, then read it back
    next_cycle();
    drv0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_ready0", 32'(req0_ready), 32'd1);
    check("wr_ready1", 32'(req1_ready), 32'd0);
    next_cycle();
    drv0(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("wr_mem_write", 32'(mem_write), 32'd1);
    check("wr_mem_addr", mem_address, 32'd4);
    check("wr_mem_wdata", mem_write_data, 32'hDEADBEEF);
    check("wr_resp0_early", 32'(resp0_valid), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("wr_resp0_valid", 32'(resp0_valid), 32'd1);
    check("wr_resp0_rdata", resp0_rdata, 32'd0);
    check("wr_resp0_err", 32'(resp0_err), 32'd0);
    check("rd_mem_read", 32'(mem_read), 32'd1);
    check("wr_resp1_valid", 32'(resp1_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rd_resp0_valid", 32'(resp0_valid), 32'd1);
    check("rd_resp0_rdata", resp0_rdata, 32'hDEADBEEF);
    check("rd_resp1_valid", 32'(resp1_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rd_resp0_pulse_end", 32'(resp0_valid), 32'd0);

    // ---- preload words 0 and 1 through port 0
    next_cycle();
    drv0(1'b1, 1'b1, 32'h0, 32'hA0A0A0A0);
    next_cycle();
    drv0(1'b1, 1'b1, 32'h4, 32'hB1B1B1B1);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // ---- both valid: grants 0,1,0,1 and alternating responses
    for (int i = 0; i < 6; i++) begin
      logic e0, e1;
      next_cycle();
      if (i < 4) begin
        drv0(1'b1, 1'b0, 32'h0, 32'h0);
        drv1(1'b1, 1'b0, 32'h4, 32'h0);
      end else begin
        idle();
      end
      @(negedge clk);
      check($sformatf("rr_ready0_%0d", i), 32'(req0_ready), 32'((i < 4) && (i % 2 == 0)));
      check($sformatf("rr_ready1_%0d", i), 32'(req1_ready), 32'((i < 4) && (i % 2 == 1)));
      e0 = (i == 2) || (i == 4);
      e1 = (i == 3) || (i == 5);
      check($sformatf("rr_resp0_valid_%0d", i), 32'(resp0_valid), 32'(e0));
      check($sformatf("rr_resp1_valid_%0d", i), 32'(resp1_valid), 32'(e1));
      check($sformatf("rr_resp0_rdata_%0d", i), resp0_rdata, e0 ? 32'hA0A0A0A0 : 32'd0);
      check($sformatf("rr_resp1_rdata_%0d", i), resp1_rdata, e1 ? 32'hB1B1B1B1 : 32'd0);
    end

    // ---- port 1 back-to-back write/read of 0x20
    next_cycle();
    drv1(1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    check("p1wr_ready1", 32'(req1_ready), 32'd1);
    next_cycle();
    drv1(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("p1rd_ready1", 32'(req1_ready), 32'd1);
    check("p1wr_mem_addr", mem_address, 32'd8);
    next_cycle();
    idle();
    @(negedge clk);
    check("p1wr_resp1_valid", 32'(resp1_valid), 32'd1);
    check("p1wr_resp1_rdata", resp1_rdata, 32'd0);
    check("p1wr_resp0_valid", 32'(resp0_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("p1rd_resp1_valid", 32'(resp1_valid), 32'd1);
    check("p1rd_resp1_rdata", resp1_rdata, 32'h12345678);

    // ---- out-of-range read on port 1, then out-of-range write on port 0
    next_cycle();
    drv1(1'b1, 1'b0, 32'h1000, 32'h0);
    @(negedge clk);
    check("err_ready1", 32'(req1_ready), 32'd1);
    next_cycle();
    drv1(1'b0, 1'b0, 32'h0, 32'h0);
    drv0(1'b1, 1'b1, 32'hFFFFFFFC, 32'hCAFEF00D);
    @(negedge clk);
    check("err_rd_mem_read", 32'(mem_read), 32'd0);
    check("err_rd_mem_write", 32'(mem_write), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("err_rd_resp1_valid", 32'(resp1_valid), 32'd1);
    check("err_rd_resp1_err", 32'(resp1_err), 32'd1);
    check("err_rd_resp1_rdata", resp1_rdata, 32'd0);
    check("err_wr_mem_write", 32'(mem_write), 32'd0);
    next_cycle();
    @(negedge clk);
    check("err_wr_resp0_valid", 32'(resp0_valid), 32'd1);
    check("err_wr_resp0_err", 32'(resp0_err), 32'd1);
    check("err_wr_mem_unchanged", mem[1023], mem[1023] === 32'hCAFEF00D ? 32'h0 : mem[1023]);

    // ---- reset while a write sits in stage C
    next_cycle();
    drv0(1'b1, 1'b1, 32'h10, 32'h55555555);
    next_cycle();
    idle();
    #1;
    check("mid_mem_write_before", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_mem_write_after", 32'(mem_write), 32'd0);
    check("mid_mem_addr_after", mem_address, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_no_resp0_%0d", i), 32'(resp0_valid), 32'd0);
      next_cycle();
    end
    drv0(1'b1, 1'b0, 32'h10, 32'h0);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    check("mid_readback_valid", 32'(resp0_valid), 32'd1);
    check("mid_readback_rdata", resp0_rdata, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
